// File: rtl/rv32_alu_pkg.sv
// Shared RV32I ALU definitions: op select codes, opcodes
// and the issue entry bundle carried by the issue stage.
package rv32_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_control;
    logic [4:0]  rd;
    logic        rd_we;
    logic        branch;
    logic [2:0]  funct3;
    logic        illegal;
  } issue_entry_t;

  function automatic logic [3:0] f3_to_alu(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    op = ALU_ADD;
    unique case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode of one instruction into an
// ALU issue entry (operands, op select, writeback info).
module alu_decode
  import rv32_alu_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  input  logic [31:0]  rs1_data,
  input  logic [31:0]  rs2_data,
  output issue_entry_t entry
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic        f7_ok;
  logic        is_shift;
  logic        wr;
  logic        ill;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25],
                   instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign f7_ok  = (f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) &&
                   ((f3 == 3'b000) || (f3 == 3'b101)));

  always_comb begin
    entry = '0;
    entry.rd = instr[11:7];
    entry.funct3 = f3;
    entry.alu_control = ALU_ADD;
    wr = 1'b0;
    ill = 1'b0;
    unique case (1'b1)
      opcode == OPC_OP: begin
        entry.operand_a = rs1_data;
        entry.operand_b = rs2_data;
        entry.alu_control = f3_to_alu(f3, f7[5]);
        wr = 1'b1;
        ill = !f7_ok;
      end
      opcode == OPC_OP_IMM: begin
        entry.operand_a = rs1_data;
        entry.operand_b = is_shift ?
          {27'b0, instr[24:20]} : imm_i;
        entry.alu_control =
          f3_to_alu(f3, is_shift & f7[5]);
        wr = 1'b1;
        ill = is_shift && !f7_ok;
      end
      opcode == OPC_LUI: begin
        entry.operand_b = imm_u;
        wr = 1'b1;
      end
      opcode == OPC_AUIPC: begin
        entry.operand_a = pc;
        entry.operand_b = imm_u;
        wr = 1'b1;
      end
      opcode == OPC_BRANCH: begin
        entry.operand_a = rs1_data;
        entry.operand_b = rs2_data;
        entry.branch = 1'b1;
        unique case (f3[2:1])
          2'b00: entry.alu_control = ALU_SUB;
          2'b10: entry.alu_control = ALU_SLT;
          2'b11: entry.alu_control = ALU_SLTU;
          default: ill = 1'b1;
        endcase
      end
      opcode == OPC_LOAD: begin
        entry.operand_a = rs1_data;
        entry.operand_b = imm_i;
        wr = 1'b1;
      end
      opcode == OPC_STORE: begin
        entry.operand_a = rs1_data;
        entry.operand_b = imm_s;
      end
      default: ill = 1'b1;
    endcase
    // Illegal entries still issue, but as a harmless ADD
    if (ill) begin
      entry.alu_control = ALU_ADD;
      entry.branch = 1'b0;
    end
    entry.illegal = ill;
    entry.rd_we = wr && !ill && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: decode into a main entry
// backed by a one-entry skid, valid/ready on both sides.
module alu_issue_stage
  import rv32_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_operand_a,
  output logic [XLEN-1:0] out_operand_b,
  output logic [3:0]      out_alu_control,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_branch,
  output logic [2:0]      out_funct3,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t       state;
  issue_entry_t dec;
  issue_entry_t main_q;
  issue_entry_t skid_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         accept;
  logic         drain;

  alu_decode u_dec (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .entry    (dec)
  );

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_q      <= dec;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q     <= dec;
            in_ready_q <= 1'b0;
            state      <= FULL;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_operand_a   = main_q.operand_a;
  assign out_operand_b   = main_q.operand_b;
  assign out_alu_control = main_q.alu_control;
  assign out_rd          = main_q.rd;
  assign out_rd_we       = main_q.rd_we;
  assign out_branch      = main_q.branch;
  assign out_funct3      = main_q.funct3;
  assign out_illegal     = main_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered decode/issue stage that drives the RV32I ALU. Accepts one instruction per cycle with its PC and register-file read data, decodes opcode/funct3/funct7 into the ALU's operand and 4-bit operation-select interface, and presents the result through a valid/ready handshake backed by a 2-entry skid buffer. It sits between register-file read and execute, and it is the only producer of `alu_control`.

## Interface
- `XLEN`, default 32: datapath width. Only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept; registered (`!skid_valid`).
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  instruction address.
- `in_rs1_data`  in  32  rs1 read value.
- `in_rs2_data`  in  32  rs2 read value.
- `flush`  in  1  discard all buffered entries (branch redirect).
- `out_valid`  out  1  issue entry valid.
- `out_ready`  in  1  execute consumes the entry.
- `out_operand_a`  out  32  ALU operand A.
- `out_operand_b`  out  32  ALU operand B.
- `out_alu_control`  out  4  ALU op: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9.
- `out_rd`  out  5  destination register.
- `out_rd_we`  out  1  writeback enable; forced to 0 when rd=0.
- `out_branch`  out  1  conditional branch; execute resolves it from the ALU result and zero flag.
- `out_funct3`  out  3  passed through for branch sense, load, and store width.
- `out_illegal`  out  1  unsupported or malformed encoding.

## Operation
- Decode rules:
  - OP (0110011): a=rs1, b=rs2. The op comes from funct3. funct7=0100000 is legal only with funct3 000 (SUB) and 101 (SRA); any other funct7 besides 0000000 is illegal. rd_we=1.
  - OP-IMM (0010011): a=rs1, b=sign-extended I-imm. For shifts (001, 101), b={27'b0, shamt}. funct7 is checked as for OP. SUB is not possible. rd_we=1.
  - LUI: a=0, b=U-imm, ADD.
  - AUIPC: a=pc, b=U-imm, ADD.
  - BRANCH: a=rs1, b=rs2, branch=1, rd_we=0. BEQ/BNE→SUB; BLT/BGE→SLT; BLTU/BGEU→SLTU; funct3 010 and 011 are illegal.
  - LOAD: a=rs1, b=I-imm, ADD, rd_we=1.
  - STORE: a=rs1, b=S-imm, ADD, rd_we=0.
  - Any other opcode is illegal.
- Illegal entries use ADD with rd_we=0 and branch=0. They are still issued, with `out_illegal`=1.
- Storage: a main entry drives the outputs; a skid entry absorbs one accept made while the main entry is stalled.
  - Transfer into the stage: `in_valid && in_ready`.
  - Transfer out of the stage: `out_valid && out_ready`.
- State: EMPTY (neither valid), ONE (main only), FULL (main and skid). Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept + drain → ONE (new entry goes to main).
  - ONE + accept without drain → FULL (new entry goes to skid).
  - ONE + drain only → EMPTY.
  - FULL + drain → ONE (skid moves to main); in_ready=0 in FULL, so no accept.
- `flush` has priority over every transfer: both entries are invalidated and any same-cycle accept is dropped. The state is EMPTY on the next cycle.
- Reset values: out_valid=0, in_ready=1; all data outputs and skid contents are 0.
- Reset mid-transfer behaves like flush: no entry survives.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears at the outputs after edge N.
- Full throughput is 1 instruction per cycle while out_ready=1.
- `in_ready` has no combinational path from `out_ready` or `in_valid`.
- Outputs are driven only from registers. Decode logic lies between the inputs and the entry registers.
- While out_valid=1 and out_ready=0, every output holds stable.

## Structure
- Package `rv32_alu_pkg`:
  - ALU op constants 0–9, shared with the ALU.
  - Opcode constants: OP, OP_IMM, LUI, AUIPC, BRANCH, LOAD, STORE.
  - `issue_entry_t` struct holding operand_a, operand_b, alu_control, rd, rd_we, branch, funct3, illegal.
- Sub-module `alu_decode`: purely combinational, mapping instr/pc/rs1/rs2 to `issue_entry_t`. It is instantiated once, and the skid buffer is in the top module.

## Test plan
- `add x3,x1,x2` with rs1=5, rs2=7, out_ready=1 → one cycle later: a=5, b=7, ctrl=0, rd=3, rd_we=1.
- `srai x4,x1,3` with rs1=0x8000_0000 → b=3, ctrl=9, illegal=0. The same encoding with funct7=0100001 → illegal=1, rd_we=0.
- `bltu x1,x2` with rs1=1, rs2=0xFFFF_FFFF → ctrl=6, branch=1, rd_we=0, funct3=110. `auipc x5,0x12345` at pc=0x100 → a=0x100, b=0x1234_5000, ctrl=0.
- Back-to-back stream with out_ready held low for 3 cycles:
  - in_ready falls after the second accept.
  - The outputs hold the first entry.
  - When out_ready rises, both entries drain in order and no data is lost or duplicated.
- flush asserted in FULL with in_valid=1 → next cycle out_valid=0 and in_ready=1; the flushed and dropped instructions never appear at the outputs.
- rst asserted mid-stream → next cycle out_valid=0, in_ready=1, and all outputs are 0. `addi x0,x0,1` → rd_we=0.
